// File: rtl/seq_shift_add_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult_pkg
// Shared types and helpers for the iterative shift-and-add multiplier.
//   state_t     : controller states (IDLE, CALC, DONE)
//   MODE_INT    : unsigned integer product
//   MODE_CLMUL  : carry-less (GF(2)[x]) product
//   calc_digits : number of digit iterations N = W / K
// -----------------------------------------------------------------------------
package seq_shift_add_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_INT   = 1'b0;
  localparam logic MODE_CLMUL = 1'b1;

  function automatic int calc_digits(input int w, input int k);
    return w / k;
  endfunction

endpackage

// File: rtl/mult_digit_step.sv
// -----------------------------------------------------------------------------
// mult_digit_step
// Combinational single-digit step of the shift-and-add multiplier. Adds (or,
// in carry-less mode, XORs) the K-bit digit partial product into the upper
// accumulator half and shifts the whole accumulator right by K.
// Optional feature macro: SEQ_SHIFT_ADD_MULT_CLMUL_EN (builds the XOR path).
// Ports:
//   acc      in  2W+K : current accumulator
//   a        in  W    : multiplicand
//   digit    in  K    : next multiplier digit (LSB first)
//   mode     in  1    : MODE_INT / MODE_CLMUL
//   acc_next out 2W+K : accumulator after this step
// -----------------------------------------------------------------------------
module mult_digit_step
  import seq_shift_add_mult_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 1
) (
  input  logic [2*DATA_WIDTH+DIGIT_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]               a,
  input  logic [DIGIT_WIDTH-1:0]              digit,
  input  logic                                mode,
  output logic [2*DATA_WIDTH+DIGIT_WIDTH-1:0] acc_next
);

  localparam int W  = DATA_WIDTH;
  localparam int K  = DIGIT_WIDTH;
  localparam int HW = W + K;

  logic [HW-1:0] a_ext;
  logic [HW-1:0] d_ext;
  logic [HW-1:0] upper;
  logic [HW-1:0] pp_int;
  logic [HW-1:0] sum;

`ifdef SEQ_SHIFT_ADD_MULT_CLMUL_EN
  logic [HW-1:0] pp_cl;

  always_comb begin
    pp_cl = '0;
    for (int i = 0; i < K; i++) begin
      if (digit[i]) pp_cl = pp_cl ^ (a_ext << i);
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  // The top K bits of acc are always zero after a shift, so the upper slice
  // (W+K bits) holds the (W)-bit high half plus headroom for the carry-out of
  // upper + a*digit, which is bounded by (2^W-1)*2^K.
  always_comb begin
    a_ext  = HW'(a);
    d_ext  = HW'(digit);
    upper  = acc[2*W+K-1:W];
    pp_int = a_ext * d_ext;
    sum    = upper + pp_int;
`ifdef SEQ_SHIFT_ADD_MULT_CLMUL_EN
    if (mode == MODE_CLMUL) sum = upper ^ pp_cl;
`endif
    acc_next = {sum, acc[W-1:0]} >> K;
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
// Iterative shift-and-add multiplier consuming DIGIT_WIDTH multiplier bits per
// clock, with valid/ready handshakes on both sides. Fixed latency of
// N = DATA_WIDTH/DIGIT_WIDTH cycles from acceptance to result; DIGIT_WIDTH must
// divide DATA_WIDTH.
// Optional feature macro: SEQ_SHIFT_ADD_MULT_CLMUL_EN
//   defined   : mode selects integer (0) or carry-less (1) product
//   undefined : mode is ignored, every operation is an integer product
// Ports:
//   clk       in  1  : clock, rising edge
//   rst       in  1  : asynchronous active-high reset
//   in_valid  in  1  : operands and mode present
//   in_ready  out 1  : block can accept (decoded from state only)
//   a         in  W  : multiplicand
//   b         in  W  : multiplier
//   mode      in  1  : product mode
//   out_valid out 1  : result available (registered)
//   out_ready in  1  : consumer takes result
//   out       out 2W : product (registered, held until next acceptance)
// -----------------------------------------------------------------------------
module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  input  logic                      mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   out
);

  localparam int W     = DATA_WIDTH;
  localparam int K     = DIGIT_WIDTH;
  localparam int N     = calc_digits(W, K);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * W + K;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc_p0;
  logic [ACC_W-1:0]  acc_next;
  logic [W-1:0]      a_p0;
  logic [W-1:0]      b_sh_p0;
  logic              mode_eff;
  logic [2*W-1:0]    out_p1;
  logic              vld_p1;
  logic              accept;

  assign in_ready  = (state == IDLE);
  assign accept    = (state == IDLE) && in_valid;
  assign out       = out_p1;
  assign out_valid = vld_p1;

  // ---- operand capture: latched on acceptance, multiplier drains LSB first
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0    <= a;
      b_sh_p0 <= b;
    end else if (state == CALC) begin
      b_sh_p0 <= b_sh_p0 >> K;
    end
  end

`ifdef SEQ_SHIFT_ADD_MULT_CLMUL_EN
  logic mode_p0;

  always_ff @(posedge clk) begin
    if (accept) mode_p0 <= mode;
  end

  assign mode_eff = mode_p0;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_eff    = MODE_INT;
`endif

  mult_digit_step #(
    .DATA_WIDTH  (W),
    .DIGIT_WIDTH (K)
  ) u_step (
    .acc      (acc_p0),
    .a        (a_p0),
    .digit    (b_sh_p0[K-1:0]),
    .mode     (mode_eff),
    .acc_next (acc_next)
  );

  // ---- controller, accumulator and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_p0 <= '0;
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state  <= CALC;
            cnt    <= '0;
            acc_p0 <= '0;
          end
        end
        CALC: begin
          acc_p0 <= acc_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            state  <= DONE;
            out_p1 <= acc_next[2*W-1:0];
            vld_p1 <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_shift_add_mult.md
# seq_shift_add_mult

Iterative, parametrised shift-and-add multiplier: the sequential successor of the combinational ripple-carry array multiplier. It trades area for latency by processing `DIGIT_WIDTH` multiplier bits per clock. It adds a valid/ready handshake on both sides and a carry-less (GF(2)[x]) product mode for the finite-field datapath. It sits between operand-issue logic and the field-reduction stage.

## Interface
- `DATA_WIDTH`, 32: operand width W; result is 2W bits.
- `DIGIT_WIDTH`, 1: multiplier bits consumed per cycle, K; must divide W; N = W/K.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operands and mode present.
- `in_ready` out 1: block can accept.
- `a` in W: multiplicand.
- `b` in W: multiplier.
- `mode` in 1: 0 = integer unsigned product, 1 = carry-less product.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `out` out 2W: product.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - CALC: digit counter runs 0..N-1.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE→CALC on `in_valid && in_ready`. Latch `a`, `b` and `mode`; clear accumulator and counter.
  - CALC: each edge, take the next K bits of latched `b` (LSB first) and form the digit partial product with `a`.
    - Integer mode: add it into the upper accumulator half with carry, then shift the accumulator right K.
    - Carry-less mode: XOR it in with no carry propagation.
  - CALC→DONE on the edge completing digit N-1.
  - DONE→IDLE on `out_ready`.
- Accumulator width 2W+K.
  - Integer: exact unsigned product, no overflow possible.
  - Carry-less: `out[2W-1]` is always 0.
- `in_valid` outside IDLE is ignored; no queuing, no overlap.
- Operand or `mode` changes after acceptance have no effect.
- `b`=0 or `a`=0 still takes the full N cycles; latency is fixed, with no early termination.
- `out` holds the last product stable from DONE until the next acceptance. It is not cleared on leaving DONE.
- Reset, including assertion mid-CALC or mid-DONE, forces:
  - state IDLE
  - `out`=0, `out_valid`=0, `in_ready`=1
  - accumulator and counter 0
- An in-flight operation is discarded on reset.

## Timing
- Acceptance edge = edge 0; result registered at edge N; `out_valid` high in the cycle after edge N.
  - W=32, K=1: 32 cycles.
  - W=8, K=4: 2 cycles.
- `in_ready` deasserts in the cycle after acceptance. It reasserts in the cycle after the `out_ready` handshake edge.
- Back-to-back throughput: one result per N+2 cycles with `out_ready` tied high.
- `out_valid` and `out` are registered outputs. `in_ready` is decoded from the state register only, with no combinational path from `in_valid` or `out_ready`.
- Critical path: one K×W digit partial product plus a (W+K)-bit ripple add.

## Configuration
- Macro: `SEQ_SHIFT_ADD_MULT_CLMUL_EN`.
- Defined: `mode` is honoured and carry-less mode is available.
- Undefined:
  - The `mode` port remains but is ignored; all operations are integer.
  - The XOR datapath and mode register are not built.

## Structure
- Package `seq_shift_add_mult_pkg`:
  - state enum (IDLE, CALC, DONE)
  - mode constants `MODE_INT`=0, `MODE_CLMUL`=1
  - function computing N from W and K
- Sub-module `mult_digit_step`: combinational step producing the next accumulator from the accumulator, `a`, the K-bit digit and the mode.
  - Instanced once.
  - Reusable by the future pipelined unrolled variant.
- Top module holds the FSM, counter, operand registers and handshake.

## Test plan
- W=8, K=1, mode 0: `a`=0xFF, `b`=0xFF → `out`=0xFE01; `out_valid` rises exactly 8 cycles after the acceptance edge.
- W=8, K=1, mode 1: `a`=0x03, `b`=0x03 → `out`=0x0005; `a`=0xFF, `b`=0xFF → `out`=0x5555.
- W=8, K=4: `a`=0xFF, `b`=0x01 → `out`=0x00FF after 2 cycles. `out_ready` held low 5 cycles → `out` and `out_valid` stable throughout, `in_ready`=0.
- Pulse `in_valid` with new operands during CALC → ignored; result matches the first operands only.
- Assert `rst` at cycle 3 of CALC → immediately `out`=0, `out_valid`=0, `in_ready`=1. Next operation after release gives the correct product.
- W=16, K∈{1,2,4,8}: 10k random operands and modes, with random `out_ready` back-pressure, against a golden model. Repeat integer-only with `SEQ_SHIFT_ADD_MULT_CLMUL_EN` undefined and `mode` randomised (ignored).
